sram_axi_bridge: RTL and testbench



---
 rtl/sram_axi_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU instruction and data SRAM-like ports onto one AXI3 master.
// The data port gets the shared AR register first, and each port has at most one request outstanding.
//
// state   | meaning
// AR_IDLE | AR register empty, a read can be latched
// AR_BUSY | arvalid high until the interconnect takes the address
// W_IDLE  | no write outstanding
// W_SEND  | awvalid/wvalid up, each drops on its own handshake
// W_RESP  | both handshakes done, waiting for bvalid
module sram_axi_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic [1:0]  inst_size,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);
   typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

   ar_state_t   ar_state_q, ar_state_d;
   logic [31:0] ar_addr_q, ar_addr_d;
   logic [1:0]  ar_size_q, ar_size_d;
   logic        ar_id_q, ar_id_d;
   w_state_t    w_state_q, w_state_d;
   logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic [1:0]  aw_size_q, aw_size_d;
   logic        inst_rd_pend_q, inst_rd_pend_d;
   logic        data_rd_pend_q, data_rd_pend_d;
   logic        wr_pend_q, wr_pend_d;

   logic ar_free, data_rd_elig, inst_rd_elig;
   logic data_rd_acc, inst_rd_acc, data_wr_acc;
   logic r_inst, r_data;
   logic unused_axi_in;

   // Response codes, last flags and bid carry nothing this bridge acts on.
   assign unused_axi_in = ^{rresp, bresp, rlast, bid};

   assign ar_free      = (ar_state_q == AR_IDLE) | (arvalid & arready);
   assign data_rd_elig = data_req & ~data_wr & ~data_rd_pend_q & ~wr_pend_q;
   assign inst_rd_elig = inst_req & ~inst_rd_pend_q;
   assign data_rd_acc  = ar_free & data_rd_elig;
   assign inst_rd_acc  = ar_free & inst_rd_elig & ~data_rd_elig;
   assign data_wr_acc  = data_req & data_wr & (w_state_q == W_IDLE) & ~data_rd_pend_q;

   assign r_inst = rvalid & (rid == 4'd0);
   assign r_data = rvalid & (rid == 4'd1);

   assign inst_addr_ok = inst_rd_acc;
   assign data_addr_ok = data_rd_acc | data_wr_acc;
   assign inst_data_ok = r_inst;
   assign data_data_ok = r_data | bvalid;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign arid    = {3'b000, ar_id_q};
   assign araddr  = ar_addr_q;
   assign arlen   = 8'd0;
   assign arsize  = {1'b0, ar_size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = (ar_state_q == AR_BUSY);
   assign rready  = 1'b1;

   assign awid    = 4'd1;
   assign awaddr  = aw_addr_q;
   assign awlen   = 8'd0;
   assign awsize  = {1'b0, aw_size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign awvalid = awvalid_q;
   assign wid     = 4'd1;
   assign wdata   = w_data_q;
   assign wstrb   = w_strb_q;
   assign wlast   = 1'b1;
   assign wvalid  = wvalid_q;
   assign bready  = 1'b1;

   always_comb begin
      ar_state_d = ar_state_q;
      ar_addr_d  = ar_addr_q;
      ar_size_d  = ar_size_q;
      ar_id_d    = ar_id_q;
      // A new read may replace the one handshaking this cycle, keeping arvalid high.
      if (data_rd_acc | inst_rd_acc) begin
         ar_state_d = AR_BUSY;
         ar_addr_d  = data_rd_acc ? data_addr : inst_addr;
         ar_size_d  = data_rd_acc ? data_size : inst_size;
         ar_id_d    = data_rd_acc;
      end else if (arvalid & arready) begin
         ar_state_d = AR_IDLE;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_addr_d = aw_addr_q;
      aw_size_d = aw_size_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      case (w_state_q)
         W_IDLE: begin
            if (data_wr_acc) begin
               w_state_d = W_SEND;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_addr_d = data_addr;
               aw_size_d = data_size;
               w_data_d  = data_wdata;
               w_strb_d  = data_wstrb;
            end
         end
         W_SEND: begin
            awvalid_d = awvalid_q & ~awready;
            wvalid_d  = wvalid_q & ~wready;
            if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (bvalid) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      inst_rd_pend_d = inst_rd_acc | (inst_rd_pend_q & ~r_inst);
      data_rd_pend_d = data_rd_acc | (data_rd_pend_q & ~r_data);
      wr_pend_d      = data_wr_acc | (wr_pend_q & ~bvalid);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ar_state_q     <= AR_IDLE;
         ar_addr_q      <= '0;
         ar_size_q      <= '0;
         ar_id_q        <= 1'b0;
         w_state_q      <= W_IDLE;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         aw_addr_q      <= '0;
         aw_size_q      <= '0;
         w_data_q       <= '0;
         w_strb_q       <= '0;
         inst_rd_pend_q <= 1'b0;
         data_rd_pend_q <= 1'b0;
         wr_pend_q      <= 1'b0;
      end else begin
         ar_state_q     <= ar_state_d;
         ar_addr_q      <= ar_addr_d;
         ar_size_q      <= ar_size_d;
         ar_id_q        <= ar_id_d;
         w_state_q      <= w_state_d;
         awvalid_q      <= awvalid_d;
         wvalid_q       <= wvalid_d;
         aw_addr_q      <= aw_addr_d;
         aw_size_q      <= aw_size_d;
         w_data_q       <= w_data_d;
         w_strb_q       <= w_strb_d;
         inst_rd_pend_q <= inst_rd_pend_d;
         data_rd_pend_q <= data_rd_pend_d;
         wr_pend_q      <= wr_pend_d;
      end
   end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: response-routing table, directed corner sequences,
// then random CPU/AXI traffic checked against a transaction-level model.
module tb_sram_axi_bridge;
   logic        clk, reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [1:0]  inst_size;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst, awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid, bready;

   int n_vec = 0;
   int n_err = 0;

   sram_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      inst_req = 1'b0; inst_addr = '0; inst_size = 2'd0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
      data_addr = '0; data_wdata = '0;
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      rid = 4'd0; rdata = '0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
      bid = 4'd1; bresp = 2'd0; bvalid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      logic        rvalid;
      logic [3:0]  rid;
      logic        bvalid;
      logic [31:0] rdata;
      logic        exp_inst_ok;
      logic        exp_data_ok;
   } resp_vec_t;
   resp_vec_t tbl[8];

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        id;
   } ar_rec_t;
   ar_rec_t     ar_q[$];
   logic        rd_q[$];
   bit          m_ipend, m_dpend, m_aw, m_w, m_wsend, m_bdue;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_awsize;
   bit          ar_busy, ar_free, d_rd, d_wr, i_rd;

   initial begin
      tbl[0] = '{1'b0, 4'd0, 1'b0, 32'haaaa5555, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 4'd0, 1'b0, 32'h02800c04, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 4'd1, 1'b0, 32'h12345678, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 4'd1, 1'b1, 32'h0badf00d, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 4'd0, 1'b1, 32'hcafe0001, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 4'd2, 1'b0, 32'h00000002, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 4'd9, 1'b0, 32'hffffffff, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 4'd0, 1'b1, 32'h5a5a5a5a, 1'b0, 1'b1};

      reset = 1'b1;
      idle_inputs();
      #12;
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("ar_const", 32'({arlen, arburst, arlock, arcache, arprot}), 32'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
      chk("aw_const", 32'({awlen, awburst, awlock, awcache, awprot, awid}), 32'({8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd1}));
      chk("w_const", 32'({wid, wlast, rready, bready}), 32'({4'd1, 1'b1, 1'b1, 1'b1}));

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         rvalid = tbl[i].rvalid; rid = tbl[i].rid; bvalid = tbl[i].bvalid; rdata = tbl[i].rdata;
         #1;
         chk($sformatf("tbl%0d_inst_ok", i), 32'(inst_data_ok), 32'(tbl[i].exp_inst_ok));
         chk($sformatf("tbl%0d_data_ok", i), 32'(data_data_ok), 32'(tbl[i].exp_data_ok));
         chk($sformatf("tbl%0d_inst_rdata", i), inst_rdata, tbl[i].rdata);
         chk($sformatf("tbl%0d_data_rdata", i), data_rdata, tbl[i].rdata);
      end
      do_reset();

      // single instruction read
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h1c000000; inst_size = 2'd2; arready = 1'b1;
      #1;
      chk("s1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      chk("s1_arvalid_t", 32'(arvalid), 32'd0);
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      chk("s1_arvalid", 32'(arvalid), 32'd1);
      chk("s1_araddr", araddr, 32'h1c000000);
      chk("s1_arid_size", 32'({arid, arsize}), 32'({4'd0, 3'd2}));
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h02800c04;
      #1;
      chk("s1_inst_data_ok", 32'(inst_data_ok), 32'd1);
      chk("s1_inst_rdata", inst_rdata, 32'h02800c04);
      chk("s1_arvalid_done", 32'(arvalid), 32'd0);
      @(negedge clk);
      rvalid = 1'b0;

      // instruction and data read together: data wins
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h1c000010; inst_size = 2'd2;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h2000; data_size = 2'd1;
      #1;
      chk("s2_data_addr_ok", 32'(data_addr_ok), 32'd1);
      chk("s2_inst_blocked", 32'(inst_addr_ok), 32'd0);
      @(negedge clk);
      data_req = 1'b0; arready = 1'b1;
      #1;
      chk("s2_ar_data", 32'({arvalid, arid, arsize}), 32'({1'b1, 4'd1, 3'd1}));
      chk("s2_araddr_data", araddr, 32'h2000);
      chk("s2_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      chk("s2_ar_inst", 32'({arvalid, arid}), 32'({1'b1, 4'd0}));
      chk("s2_araddr_inst", araddr, 32'h1c000010);
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h11112222;
      #1;
      chk("s2_rsp_data", 32'({inst_data_ok, data_data_ok}), 32'b01);
      chk("s2_data_rdata", data_rdata, 32'h11112222);
      @(negedge clk);
      rid = 4'd0; rdata = 32'h33334444;
      #1;
      chk("s2_rsp_inst", 32'({inst_data_ok, data_data_ok}), 32'b10);
      @(negedge clk);
      rvalid = 1'b0;

      // write with wready two cycles ahead of awready, then a blocked data read
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1000; data_wdata = 32'hdeadbeef;
      data_wstrb = 4'b0011; data_size = 2'd2;
      #1;
      chk("s3_wr_addr_ok", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 1'b0; wready = 1'b1;
      #1;
      chk("s3_valids", 32'({awvalid, wvalid}), 32'b11);
      chk("s3_awaddr", awaddr, 32'h1000);
      chk("s3_wdata", wdata, 32'hdeadbeef);
      chk("s3_wstrb_size", 32'({wstrb, awsize}), 32'({4'b0011, 3'd2}));
      @(negedge clk);
      wready = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h3000; data_size = 2'd2;
      #1;
      chk("s3_w_dropped", 32'({awvalid, wvalid}), 32'b10);
      chk("s3_rd_blocked0", 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      awready = 1'b1;
      #1;
      chk("s3_aw_held", 32'({awvalid, wvalid}), 32'b10);
      chk("s3_rd_blocked1", 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      awready = 1'b0;
      #1;
      chk("s3_valids_done", 32'({awvalid, wvalid}), 32'b00);
      chk("s3_rd_blocked2", 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      bvalid = 1'b1;
      #1;
      chk("s3_b_data_ok", 32'(data_data_ok), 32'd1);
      chk("s3_rd_blocked_b", 32'(data_addr_ok), 32'd0);
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      chk("s3_rd_accepted", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 1'b0; arready = 1'b1;
      #1;
      chk("s3_ar", 32'({arvalid, arid}), 32'({1'b1, 4'd1}));
      chk("s3_araddr", araddr, 32'h3000);
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h77778888;
      #1;
      chk("s3_rd_data_ok", 32'(data_data_ok), 32'd1);
      @(negedge clk);
      rvalid = 1'b0;

      // reset in the middle of a read address and a write
      @(negedge clk);
      inst_req = 1'b1; inst_addr = 32'h1c000040; inst_size = 2'd2;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h1004; data_wdata = 32'h01020304; data_wstrb = 4'hf;
      #1;
      chk("s6_both_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b11);
      @(negedge clk);
      inst_req = 1'b0; data_req = 1'b0;
      #1;
      chk("s6_pre_valids", 32'({arvalid, awvalid, wvalid}), 32'b111);
      #1;
      reset = 1'b1;
      #1;
      chk("s6_rst_valids", 32'({arvalid, awvalid, wvalid}), 32'b000);
      chk("s6_rst_flags", 32'({dut.inst_rd_pend_q, dut.data_rd_pend_q, dut.wr_pend_q}), 32'b000);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h4000; arready = 1'b1;
      #1;
      chk("s6_post_data_ok", 32'(data_addr_ok), 32'd1);
      @(negedge clk);
      data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h1c000080;
      #1;
      chk("s6_post_inst_ok", 32'(inst_addr_ok), 32'd1);
      chk("s6_post_ar", 32'({arvalid, arid}), 32'({1'b1, 4'd1}));
      do_reset();

      // random traffic against the transaction-level model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         inst_req   = ($urandom_range(0, 2) == 0);
         inst_addr  = $urandom;
         inst_size  = 2'($urandom_range(0, 2));
         data_req   = ($urandom_range(0, 2) == 0);
         data_wr    = 1'($urandom_range(0, 1));
         data_addr  = $urandom;
         data_wdata = $urandom;
         data_wstrb = 4'($urandom);
         data_size  = 2'($urandom_range(0, 2));
         arready    = ($urandom_range(0, 3) != 0);
         awready    = 1'($urandom_range(0, 1));
         wready     = 1'($urandom_range(0, 1));
         rvalid = 1'b0; rid = 4'($urandom); rdata = $urandom; bvalid = 1'b0;
         if (rd_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            rvalid = 1'b1;
            rid = {3'b000, rd_q[0]};
         end
         if (m_bdue && $urandom_range(0, 2) == 0) bvalid = 1'b1;
         #1;
         ar_busy = (ar_q.size() != 0);
         ar_free = !ar_busy || arready;
         d_rd = data_req && !data_wr && !m_dpend;
         d_wr = data_req && data_wr && !m_dpend;
         i_rd = inst_req && !m_ipend && ar_free && !d_rd;
         chk("rnd_inst_addr_ok", 32'(inst_addr_ok), 32'(i_rd));
         chk("rnd_data_addr_ok", 32'(data_addr_ok), 32'((d_rd && ar_free) || d_wr));
         chk("rnd_arvalid", 32'(arvalid), 32'(ar_busy));
         if (ar_busy) begin
            chk("rnd_araddr", araddr, ar_q[0].addr);
            chk("rnd_arid_size", 32'({arid, arsize}), 32'({3'b000, ar_q[0].id, 1'b0, ar_q[0].size}));
         end
         chk("rnd_awvalid", 32'(awvalid), 32'(m_aw));
         if (m_aw) chk("rnd_aw", 32'({awsize, awaddr[27:0]}), 32'({1'b0, m_awsize, m_awaddr[27:0]}));
         chk("rnd_wvalid", 32'(wvalid), 32'(m_w));
         if (m_w) begin
            chk("rnd_wdata", wdata, m_wdata);
            chk("rnd_wstrb", 32'(wstrb), 32'(m_wstrb));
         end
         chk("rnd_inst_data_ok", 32'(inst_data_ok), 32'(rvalid && rid == 4'd0));
         chk("rnd_data_data_ok", 32'(data_data_ok), 32'((rvalid && rid == 4'd1) || bvalid));
         chk("rnd_rdata", data_rdata, rdata);

         if (rvalid) begin
            if (rd_q[0]) m_dpend = 1'b0;
            else m_ipend = 1'b0;
            void'(rd_q.pop_front());
         end
         if (ar_busy && arready) begin
            rd_q.push_back(ar_q[0].id);
            void'(ar_q.pop_front());
         end
         if (bvalid) begin
            m_bdue = 1'b0;
            m_dpend = 1'b0;
         end
         if (m_aw && awready) m_aw = 1'b0;
         if (m_w && wready) m_w = 1'b0;
         if (m_wsend && !m_aw && !m_w) begin
            m_wsend = 1'b0;
            m_bdue = 1'b1;
         end
         if (d_rd && ar_free) begin
            ar_q.push_back('{data_addr, data_size, 1'b1});
            m_dpend = 1'b1;
         end else if (i_rd) begin
            ar_q.push_back('{inst_addr, inst_size, 1'b0});
            m_ipend = 1'b1;
         end
         if (d_wr) begin
            m_dpend = 1'b1; m_wsend = 1'b1; m_aw = 1'b1; m_w = 1'b1;
            m_awaddr = data_addr; m_awsize = data_size; m_wdata = data_wdata; m_wstrb = data_wstrb;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
